// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction at a time through fetch, execute and writeback over an 8x16 register file.
// Latency: writeback lands 2 cycles after acceptance, with done in the following cycle; 3 cycles per instruction.
// Backpressure: instr_ready is high only in IDLE; instr_valid offered while busy is ignored and must be held.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zero_x,
    output logic        alu_zero_y,
    output logic        alu_negate,
    output logic [1:0]  alu_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_is_zero,
    input  logic        alu_is_negative,
    output logic        zero_flag,
    output logic        neg_flag,
    output logic        done,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef struct packed {
        logic [1:0] opcode;
        logic       zero_x;
        logic       zero_y;
        logic       negate;
        logic [2:0] dst;
        logic [2:0] src_x;
        logic [2:0] src_y;
        logic       flag_we;
        logic       reg_we;
    } ir_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    ir_t         ir_q, ir_d;
    ir_t         instr_f;
    logic [15:0] rf_q [8];
    logic [15:0] alu_x_q, alu_x_d;
    logic [15:0] alu_y_q, alu_y_d;
    logic        zero_flag_q, zero_flag_d;
    logic        neg_flag_q, neg_flag_d;
    logic        done_q, done_d;
    logic        accept;
    logic        wb_fire;

    assign instr_f = ir_t'(instr);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        accept  = 1'b0;
        wb_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    accept  = 1'b1;
                    ir_d    = instr_f;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                wb_fire = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands are sampled at acceptance; writeback of the previous instruction has
    // already landed by then, so these equal the register values seen during EXEC.
    always_comb begin
        alu_x_d     = alu_x_q;
        alu_y_d     = alu_y_q;
        zero_flag_d = zero_flag_q;
        neg_flag_d  = neg_flag_q;
        done_d      = wb_fire;
        if (accept) begin
            alu_x_d = rf_q[instr_f.src_x];
            alu_y_d = rf_q[instr_f.src_y];
        end
        if (wb_fire && ir_q.flag_we) begin
            zero_flag_d = alu_is_zero;
            neg_flag_d  = alu_is_negative;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            zero_flag_q <= 1'b0;
            neg_flag_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            zero_flag_q <= zero_flag_d;
            neg_flag_q  <= neg_flag_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_fire && ir_q.reg_we) begin
            rf_q[ir_q.dst] <= alu_result;
        end
    end

    // Control bits come straight from ir, which only changes at the next acceptance.
    assign alu_zero_x  = ir_q.zero_x;
    assign alu_zero_y  = ir_q.zero_y;
    assign alu_negate  = ir_q.negate;
    assign alu_opcode  = ir_q.opcode;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign instr_ready = (state_q == S_IDLE) && !reset;
    assign zero_flag   = zero_flag_q;
    assign neg_flag    = neg_flag_q;
    assign done        = done_q;
    assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the operand bus plus an array-based reference of registers and flags.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_x, alu_y;
    logic        alu_zero_x, alu_zero_y, alu_negate;
    logic [1:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_is_zero, alu_is_negative;
    logic        zero_flag, neg_flag, done;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_rf [8];
    logic        m_z, m_n;

    alu_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_ready    (instr_ready),
        .alu_x          (alu_x),
        .alu_y          (alu_y),
        .alu_zero_x     (alu_zero_x),
        .alu_zero_y     (alu_zero_y),
        .alu_negate     (alu_negate),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .alu_is_zero    (alu_is_zero),
        .alu_is_negative(alu_is_negative),
        .zero_flag      (zero_flag),
        .neg_flag       (neg_flag),
        .done           (done),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic zx, input logic zy,
                                           input logic ng, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, r;
        x = zx ? 16'h0000 : a;
        y = zy ? 16'h0000 : b;
        case (op)
            2'd0:    r = x | y;
            2'd1:    r = x & y;
            2'd2:    r = x + y;
            default: r = x - y;
        endcase
        return ng ? ~r : r;
    endfunction

    // External ALU: result and flags appear one cycle after operands are presented.
    logic [15:0] alu_now;
    assign alu_now = alu_fn(alu_opcode, alu_zero_x, alu_zero_y, alu_negate, alu_x, alu_y);
    always @(posedge clk) begin
        alu_result      <= alu_now;
        alu_is_zero     <= (alu_now == 16'h0000);
        alu_is_negative <= alu_now[15];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input bit zx, input bit zy, input bit ng, input int dst,
                                       input int sx, input int sy, input bit fwe, input bit rwe);
        return {op[1:0], zx, zy, ng, dst[2:0], sx[2:0], sy[2:0], fwe, rwe};
    endfunction

    function automatic logic [15:0] ref_result(input logic [15:0] ins);
        return alu_fn(ins[15:14], ins[13], ins[12], ins[11], m_rf[ins[7:5]], m_rf[ins[4:2]]);
    endfunction

    task automatic model_retire(input logic [15:0] ins);
        logic [15:0] r;
        r = ref_result(ins);
        if (ins[0]) m_rf[ins[10:8]] = r;
        if (ins[1]) begin
            m_z = (r == 16'h0000);
            m_n = r[15];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, m_rf[i]});
        end
        check_eq({tag, "_zero_flag"}, {31'h0, zero_flag}, {31'h0, m_z});
        check_eq({tag, "_neg_flag"}, {31'h0, neg_flag}, {31'h0, m_n});
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq({tag, "_ready_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_ready_low", {31'h0, instr_ready}, 32'h0);
        @(negedge clk);
        check_eq("rst_done_low", {31'h0, done}, 32'h0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("post_rst_ready", {31'h0, instr_ready}, 32'h1);
        check_eq("post_rst_done", {31'h0, done}, 32'h0);
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_instr(input string tag, input logic [15:0] ins, input bit noise);
        instr       = ins;
        instr_valid = 1'b1;
        wait_ready(tag);
        @(negedge clk);
        check_eq({tag, "_exec_ready"}, {31'h0, instr_ready}, 32'h0);
        check_eq({tag, "_alu_x"}, {16'h0, alu_x}, {16'h0, m_rf[ins[7:5]]});
        check_eq({tag, "_alu_y"}, {16'h0, alu_y}, {16'h0, m_rf[ins[4:2]]});
        check_eq({tag, "_alu_ctl"}, {27'h0, alu_opcode, alu_zero_x, alu_zero_y, alu_negate},
                 {27'h0, ins[15:14], ins[13], ins[12], ins[11]});
        if (noise) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_wb_ready"}, {31'h0, instr_ready}, 32'h0);
        check_eq({tag, "_wb_done"}, {31'h0, done}, 32'h0);
        if (noise) instr = 16'($urandom);
        @(negedge clk);
        instr_valid = 1'b0;
        model_retire(ins);
        check_eq({tag, "_done"}, {31'h0, done}, 32'h1);
        check_eq({tag, "_ready_back"}, {31'h0, instr_ready}, 32'h1);
        check_state(tag);
        @(negedge clk);
        check_eq({tag, "_done_once"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        logic [15:0] q [3];
        logic [15:0] ins;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        model_reset();
        m_rf[0] = 16'h0000;

        do_reset();
        check_eq("rst_alu_x", {16'h0, alu_x}, 32'h0);
        check_eq("rst_alu_y", {16'h0, alu_y}, 32'h0);
        check_eq("rst_alu_ctl", {27'h0, alu_opcode, alu_zero_x, alu_zero_y, alu_negate}, 32'h0);
        check_state("rst");

        run_instr("add_r1", mk(2, 0, 0, 0, 1, 0, 0, 1, 1), 1'b0);
        check_eq("add_r1_zf_const", {31'h0, zero_flag}, 32'h1);
        run_instr("or_r2", mk(0, 1, 1, 1, 2, 0, 0, 1, 1), 1'b0);
        run_instr("sub_r3", mk(3, 0, 0, 0, 3, 2, 1, 1, 1), 1'b0);
        dbg_addr = 3'd3;
        #1;
        check_eq("r3_const", {16'h0, dbg_data}, 32'hFFFF);
        check_eq("sub_neg_const", {31'h0, neg_flag}, 32'h1);
        run_instr("add_wrap", mk(2, 0, 0, 0, 2, 2, 2, 1, 1), 1'b0);
        dbg_addr = 3'd2;
        #1;
        check_eq("r2_wrap_const", {16'h0, dbg_data}, 32'hFFFE);
        run_instr("nowrite", mk(2, 0, 0, 1, 4, 2, 3, 0, 0), 1'b1);

        q[0] = mk(0, 1, 1, 1, 6, 0, 0, 1, 1);
        q[1] = mk(2, 0, 0, 0, 7, 6, 2, 1, 1);
        q[2] = mk(1, 0, 0, 1, 6, 7, 6, 0, 1);
        instr       = q[0];
        instr_valid = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            check_eq($sformatf("b2b_ready_c%0d", c), {31'h0, instr_ready}, {31'h0, (c % 3) == 0});
            check_eq($sformatf("b2b_done_c%0d", c), {31'h0, done}, {31'h0, ((c % 3) == 0) && (c > 0)});
            if ((c % 3) == 1)
                check_eq($sformatf("b2b_alu_x_c%0d", c), {16'h0, alu_x}, {16'h0, m_rf[q[c / 3][7:5]]});
            if ((c % 3) == 0 && c > 0) begin
                model_retire(q[c / 3 - 1]);
                if (c < 9) instr = q[c / 3];
                else       instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("b2b_done_end", {31'h0, done}, 32'h0);
        check_state("b2b");

        instr       = mk(0, 1, 1, 1, 5, 0, 0, 1, 1);
        instr_valid = 1'b1;
        wait_ready("rst_wb");
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_wb_ready", {31'h0, instr_ready}, 32'h0);
        check_eq("rst_wb_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("rst_wb_ready_after", {31'h0, instr_ready}, 32'h1);
        check_eq("rst_wb_no_done", {31'h0, done}, 32'h0);
        dbg_addr = 3'd5;
        #1;
        check_eq("rst_wb_r5", {16'h0, dbg_data}, 32'h0);
        check_state("rst_wb");

        for (int k = 0; k < 40; k++) begin
            ins = 16'($urandom);
            if (k < 6) ins[13:11] = 3'b111;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_instr($sformatf("rnd%0d", k), ins, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
